// File: rtl/jk_excite_seq.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excite_seq
//  Description : Turns a serial stream of target bits into J/K excitation for
//                an external JK flip-flop, then reads q back and counts misses.
//  Revision    : 1.0  initial release
// ============================================================================
module jk_excite_seq #(
    parameter int CNT_W      = 8,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_VERIFY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_tgt;
    logic             r_j;
    logic             r_k;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_bit_cnt;

    logic [1:0]       w_jk;
    logic             w_mismatch;

    // A no-change target always holds; only real transitions use set/reset or toggle.
    always_comb begin
        w_jk = 2'b00;
        if (tgt_bit != q_fb) begin
            if (USE_TOGGLE) begin
                w_jk = 2'b11;
            end else begin
                w_jk = tgt_bit ? 2'b10 : 2'b01;
            end
        end
    end

    assign w_mismatch = q_fb ^ r_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tgt     <= 1'b0;
            r_j       <= 1'b0;
            r_k       <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_j   <= 1'b0;
            r_k   <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tgt_valid) begin
                        r_tgt      <= tgt_bit;
                        {r_j, r_k} <= w_jk;
                        r_state    <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    r_state <= S_VERIFY;
                end
                S_VERIFY: begin
                    if (r_bit_cnt != c_cnt_max) begin
                        r_bit_cnt <= r_bit_cnt + c_cnt_one;
                    end
                    if (w_mismatch) begin
                        r_err <= 1'b1;
                        if (r_err_cnt != c_cnt_max) begin
                            r_err_cnt <= r_err_cnt + c_cnt_one;
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tgt_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign j         = r_j;
    assign k         = r_k;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign bit_cnt   = r_bit_cnt;

endmodule
`default_nettype wire
